rom_loader: RTL

- Upstream stage of the computer's instruction ROM.
- Receives a framed program image as a byte stream from the existing UART receiver and writes 16-bit instructions into the instruction RAM through its write port.
- Holds the CPU in reset until a complete image has been received and its checksum matches.
- Replaces the fixed instruction table, so programs can be reloaded without resynthesis.

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_timeout.sv | 43 ++++
 rtl/rom_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for UART-fed program loaders.
package loader_pkg;

    localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
    localparam int unsigned INST_W        = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CNT_HI,
        ST_CNT_LO,
        ST_DATA_HI,
        ST_DATA_LO,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: pulses expired once after CYCLES enabled cycles without clear.
module loader_timeout #(
    parameter int unsigned CYCLES = 27_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    // Counter saturates at CYCLES so expired is a single pulse
    always_comb begin
        count_d   = count_q;
        expired_d = 1'b0;
        if (!enable || clear) begin
            count_d = '0;
        end else begin
            if (count_q != CNT_W'(CYCLES)) begin
                count_d = count_q + CNT_W'(1);
            end
            expired_d = (count_q == CNT_W'(CYCLES - 1));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/rom_loader.sv
// Receives a framed program image over UART bytes, writes it to instruction RAM
// and holds the CPU in reset until a complete, checksum-verified image is present.
module rom_loader
    import loader_pkg::*;
#(
    parameter int unsigned ADDR_W         = 15,
    parameter logic [7:0]  MAGIC          = MAGIC_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [INST_W-1:0] rom_wdata,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int unsigned WL_W  = ADDR_W + 1;
    localparam int unsigned DEPTH = 32'd1 << ADDR_W;

    loader_state_t     state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        csum_q, csum_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic              rom_we_q, rom_we_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [INST_W-1:0] rom_wdata_q, rom_wdata_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              timer_en_c;
    logic              timer_expired;
    logic              abort_c;
    logic [15:0]       n_c;
    logic [WL_W-1:0]   word_next_c;

    assign timer_en_c = state_q inside {ST_CNT_HI, ST_CNT_LO, ST_DATA_HI, ST_DATA_LO, ST_CSUM};

    loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .enable  (timer_en_c),
        .clear   (rx_valid),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        csum_d      = csum_q;
        words_d     = words_q;
        rom_we_d    = 1'b0;
        rom_addr_d  = rom_addr_q;
        rom_wdata_d = rom_wdata_q;
        cpu_reset_d = cpu_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        abort_c     = 1'b0;
        n_c         = {cnt_q[15:8], rx_data};
        word_next_c = words_q + WL_W'(1);

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rx_valid && rx_data == MAGIC) begin
                    state_d     = ST_CNT_HI;
                    words_d     = '0;
                    csum_d      = '0;
                    busy_d      = 1'b1;
                    cpu_reset_d = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                end
            end
            ST_CNT_HI: begin
                if (rx_valid) begin
                    cnt_d   = {rx_data, 8'h00};
                    state_d = ST_CNT_LO;
                end
            end
            ST_CNT_LO: begin
                if (rx_valid) begin
                    cnt_d = n_c;
                    if (n_c == 16'd0 || 32'(n_c) > DEPTH) begin
                        abort_c = 1'b1;
                    end else begin
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_DATA_HI: begin
                if (rx_valid) begin
                    hi_d    = rx_data;
                    csum_d  = csum_q ^ rx_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (rx_valid) begin
                    rom_we_d    = 1'b1;
                    rom_addr_d  = ADDR_W'(words_q);
                    rom_wdata_d = {hi_q, rx_data};
                    csum_d      = csum_q ^ rx_data;
                    words_d     = word_next_c;
                    state_d     = (32'(word_next_c) == 32'(cnt_q)) ? ST_CSUM : ST_DATA_HI;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == csum_q) begin
                        state_d     = ST_DONE;
                        done_d      = 1'b1;
                        busy_d      = 1'b0;
                        cpu_reset_d = 1'b0;
                    end else begin
                        abort_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A byte arriving in the expiry cycle takes priority over the timeout
        if (timer_en_c && !rx_valid && timer_expired) begin
            abort_c = 1'b1;
        end

        if (abort_c) begin
            state_d     = ST_ERR;
            error_d     = 1'b1;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            cpu_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            csum_q      <= '0;
            words_q     <= '0;
            rom_we_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_wdata_q <= '0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            csum_q      <= csum_d;
            words_q     <= words_d;
            rom_we_q    <= rom_we_d;
            rom_addr_q  <= rom_addr_d;
            rom_wdata_q <= rom_wdata_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rom_we       = rom_we_q;
    assign rom_addr     = rom_addr_q;
    assign rom_wdata    = rom_wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_busy    = busy_q;
    assign load_done    = done_q;
    assign load_error   = error_q;
    assign words_loaded = words_q;

endmodule
